bcd_to_bin_seq: RTL and testbench

//  Sequential BCD-to-binary converter: reverse double-dabble, one result bit per clock.

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_to_bin_seq_if.sv | 30 +++
 rtl/bcd_digit_adj_sub3.sv | 14 +
 rtl/bcd_to_bin_seq.sv | 111 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary converter.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_conv_state_t;

  // Smallest binary width w with 2**w > 10**digits - 1.
  function automatic int bin_width(input int digits);
    longint lim;
    longint pw;
    int     w;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    pw = 1;
    w  = 0;
    while (pw < lim) begin
      pw = pw * 2;
      w  = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/response bundle for the BCD-to-binary converter.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid and payload stay stable until that edge, and ready never
// depends combinationally on the opposite side's valid.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      out_bin;
  logic                  out_err;

  // Producer of BCD words and consumer of results.
  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  // The converter itself.
  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );

endinterface

// File: rtl/bcd_digit_adj_sub3.sv
// Reverse double-dabble digit correction: a digit of 8 or more loses 3.
module bcd_digit_adj_sub3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  // Pure 4-bit compare/subtract, no carry out of the digit.
  always_comb begin
    digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one result bit per clock
// (reverse double-dabble). Non-decimal digits produce an error result.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_to_bin_seq_if.slave bus,
  output bcd_conv_state_t state_o
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  if (BIN_W < bin_width(DIGITS)) begin : g_width_check
    $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
  end

  bcd_conv_state_t      state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic                 err_q, err_d;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_adj;
  logic                   in_bad;

  // One right shift of the joint register: bcd LSB becomes bin MSB.
  assign shifted = {bcd_q, bin_q} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj_sub3 u_adj (
      .digit_i (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .digit_o (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Flag any incoming digit above 9.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.in_bcd[i*DIGIT_W +: DIGIT_W] > 4'd9) in_bad = 1'b1;
    end
  end

  // State, counter and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (in_bad) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            bcd_d   = bus.in_bcd;
            bin_d   = '0;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on state only; the result is hidden outside DONE.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_bin   = (state_q == DONE) ? bin_q : '0;
  assign bus.out_err   = (state_q == DONE) && err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq with a result scoreboard.
module tb_bcd_to_bin_seq;
  import bcd_pkg::*;

  logic clk;
  logic rst_n;
  bcd_conv_state_t state_o;

  bcd_to_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bus ();

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  int checks   = 0;
  int failures = 0;
  logic [14:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0d expected=none", bus.out_bin);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        check("out_bin", 32'(bus.out_bin), 32'(e[13:0]));
        check("out_err", 32'(bus.out_err), 32'(e[14]));
      end
    end
  end

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; observations are taken there too.
  task automatic send(input logic [15:0] bcd, input logic [13:0] exp_bin,
                      input logic exp_err, input int exp_lat,
                      input logic hold_busy, input int stall);
    int n;
    int lat;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.out_ready = (stall == 0);
    bus.in_bcd    = bcd;
    bus.in_valid  = 1'b1;
    exp_q.push_back({exp_err, exp_bin});
    @(posedge clk); #1;
    if (hold_busy) bus.in_bcd = 16'h5678;
    else           bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (hold_busy) check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    bus.in_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_out_bin", 32'(bus.out_bin), 32'(exp_bin));
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_return", 32'(bus.in_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bin", 32'(bus.out_bin), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(16'h0000, 14'd0,    1'b0, 14, 1'b0, 0);
    send(16'h9999, 14'd9999, 1'b0, 14, 1'b0, 0);
    send(16'h1234, 14'd1234, 1'b0, 14, 1'b1, 0);
    send(16'h12A4, 14'd0,    1'b1, 0,  1'b0, 0);
    send(16'h0042, 14'd42,   1'b0, 14, 1'b0, 0);
    send(16'h0815, 14'd815,  1'b0, 14, 1'b0, 5);
    send(16'h9000, 14'd9000, 1'b0, 14, 1'b0, 0);
    send(16'hF000, 14'd0,    1'b1, 0,  1'b0, 0);
    send(16'h0007, 14'd7,    1'b0, 14, 1'b0, 0);

    // Abort a conversion with an asynchronous reset after 7 iterations.
    bus.in_bcd   = 16'h0999;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_out_bin", 32'(bus.out_bin), 32'd0);
    check("abort_out_err", 32'(bus.out_err), 32'd0);
    check("abort_state", 32'(state_o), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0001, 14'd1, 1'b0, 14, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
